// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multicycle MIPS core
//
// Sequences fetch/decode/execute/memory/writeback one state per clock and
// decodes the ALU operation directly (there is no separate ALU-control block).
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   opcode, func, ZERO   IR[31:26], IR[5:0] and the ALU zero flag
//   pc_write .. mem_read single-bit datapath controls
//   alu_src_B            00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   pc_src               00=ALU result, 01=jump target, 10=A, 11=AluOut
//   alu_op               000=add, 001=sub, 010=and, 011=or, 100=slt
//   halted               trap indicator
//
// Optional feature macro ILLEGAL_TRAP_EN: when defined, an illegal opcode
// parks the FSM in a sticky halt state with halted=1; otherwise the illegal
// state is a one-cycle NOP and halted is tied to 0.
module multicycle_controller #(
  parameter int ALU_OP_W = 3,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic                ZERO,
  output logic                pc_write,
  output logic                IR_write,
  output logic                reg_dst,
  output logic                jal_reg,
  output logic                pc_to_reg,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_A,
  output logic                I_or_D,
  output logic                mem_write,
  output logic                mem_read,
  output logic [1:0]          alu_src_B,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR,
    S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:        state_d = (func == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`else
      S_ILLEGAL:  state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the current state and gated by rst directly, so
  // they drop to 0 the moment reset asserts and FETCH controls appear as soon
  // as it releases, ahead of the first edge.
  always_comb begin
    pc_write   = 1'b0;
    IR_write   = 1'b0;
    reg_dst    = 1'b0;
    jal_reg    = 1'b0;
    pc_to_reg  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_A  = 1'b0;
    I_or_D     = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    alu_src_B  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          IR_write  = 1'b1;
          alu_src_B = 2'b01;
          pc_write  = 1'b1;
        end
        S_DECODE:   alu_src_B = 2'b11;
        S_MEM_ADDR: begin
          alu_src_A = 1'b1;
          alu_src_B = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          I_or_D   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          I_or_D    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_A = 1'b1;
          case (func)
            6'b100010: alu_op = ALU_SUB;
            6'b100100: alu_op = ALU_AND;
            6'b100101: alu_op = ALU_OR;
            6'b101010: alu_op = ALU_SLT;
            default:   alu_op = ALU_ADD;
          endcase
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_A = 1'b1;
          alu_src_B = 2'b10;
          alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_I_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_A = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = 2'b11;
          // beq takes the branch on ZERO, bne on its complement.
          pc_write  = (opcode == OP_BNE) ? ~ZERO : ZERO;
        end
        S_JUMP: begin
          pc_src   = 2'b01;
          pc_write = 1'b1;
        end
        S_JAL: begin
          pc_src    = 2'b01;
          pc_write  = 1'b1;
          reg_write = 1'b1;
          jal_reg   = 1'b1;
          pc_to_reg = 1'b1;
        end
        S_JR: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_ILLEGAL: halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic       ZERO = 1'b0;
  logic       pc_write, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg;
  logic       reg_write, alu_src_A, I_or_D, mem_write, mem_read, halted;
  logic [1:0] alu_src_B, pc_src;
  logic [2:0] alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ZERO(ZERO),
    .pc_write(pc_write), .IR_write(IR_write), .reg_dst(reg_dst),
    .jal_reg(jal_reg), .pc_to_reg(pc_to_reg), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_A(alu_src_A), .I_or_D(I_or_D),
    .mem_write(mem_write), .mem_read(mem_read), .alu_src_B(alu_src_B),
    .pc_src(pc_src), .alu_op(alu_op), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [18:0] ctl;
  assign ctl = {pc_write, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg,
                reg_write, alu_src_A, I_or_D, mem_write, mem_read,
                alu_src_B, pc_src, alu_op, halted};

  function automatic logic [18:0] cv(
    input logic pw, irw, rd, jr, ptr, mtr, rw, asa, iod, mw, mr,
    input logic [1:0] asb, input logic [1:0] psrc, input logic [2:0] aop,
    input logic h);
    return {pw, irw, rd, jr, ptr, mtr, rw, asa, iod, mw, mr, asb, psrc, aop, h};
  endfunction

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  //                          pw irw rd jr ptr mtr rw asa iod mw mr  asb    psrc   aop     h
  localparam logic [18:0] V_ZERO   = cv(0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_FETCH  = cv(1,1,0,0,0,0,0,0,0,0,1, 2'b01, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_DECODE = cv(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_MADDR  = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b10, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_MRD    = cv(0,0,0,0,0,0,0,0,1,0,1, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_MWB    = cv(0,0,0,0,0,1,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_MWR    = cv(0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_RSLT   = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b100, 0);
  localparam logic [18:0] V_RSUB   = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b001, 0);
  localparam logic [18:0] V_ROR    = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b011, 0);
  localparam logic [18:0] V_RADD   = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_RWB    = cv(0,0,1,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_IADD   = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b10, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_ISLT   = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b10, 2'b00, 3'b100, 0);
  localparam logic [18:0] V_IWB    = cv(0,0,0,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [18:0] V_BR_T   = cv(1,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b11, 3'b001, 0);
  localparam logic [18:0] V_BR_N   = cv(0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b11, 3'b001, 0);
  localparam logic [18:0] V_JUMP   = cv(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 3'b000, 0);
  localparam logic [18:0] V_JAL    = cv(1,0,0,1,1,0,1,0,0,0,0, 2'b00, 2'b01, 3'b000, 0);
  localparam logic [18:0] V_JR     = cv(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0);
  localparam logic [18:0] V_ILL    = cv(0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, TRAP);

  task automatic check(input string tag, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Check the current state's outputs, then advance one clock.
  task automatic step(input string tag, input logic [18:0] exp);
    check(tag, ctl, exp);
    @(negedge clk);
  endtask

  task automatic load(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    func   = fn;
    ZERO   = z;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", ctl, V_ZERO);
    rst = 1'b1;
    #1;

    load(6'b100011, 6'd0, 1'b0);
    step("lw_fetch", V_FETCH);
    step("lw_decode", V_DECODE);
    step("lw_mem_addr", V_MADDR);
    step("lw_mem_rd", V_MRD);
    step("lw_mem_wb", V_MWB);

    load(6'b101011, 6'd0, 1'b0);
    step("sw_fetch", V_FETCH);
    step("sw_decode", V_DECODE);
    step("sw_mem_addr", V_MADDR);
    step("sw_mem_wr", V_MWR);

    load(6'b000000, 6'b101010, 1'b0);
    step("slt_fetch", V_FETCH);
    step("slt_decode", V_DECODE);
    step("slt_exec", V_RSLT);
    step("slt_wb", V_RWB);

    load(6'b000000, 6'b100010, 1'b0);
    step("sub_fetch", V_FETCH);
    step("sub_decode", V_DECODE);
    step("sub_exec", V_RSUB);
    step("sub_wb", V_RWB);

    load(6'b000000, 6'b100101, 1'b0);
    repeat (2) @(negedge clk);
    step("or_exec", V_ROR);
    @(negedge clk);

    load(6'b000000, 6'b111111, 1'b0);
    repeat (2) @(negedge clk);
    step("rfunc_default_exec", V_RADD);
    @(negedge clk);

    load(6'b001000, 6'd0, 1'b0);
    step("addi_fetch", V_FETCH);
    @(negedge clk);
    step("addi_exec", V_IADD);
    step("addi_wb", V_IWB);

    load(6'b001010, 6'd0, 1'b0);
    repeat (2) @(negedge clk);
    step("slti_exec", V_ISLT);
    step("slti_wb", V_IWB);

    load(6'b000100, 6'd0, 1'b1);
    step("beq1_fetch", V_FETCH);
    step("beq1_decode", V_DECODE);
    step("beq_zero1", V_BR_T);

    load(6'b000100, 6'd0, 1'b0);
    repeat (2) @(negedge clk);
    step("beq_zero0", V_BR_N);

    load(6'b000101, 6'd0, 1'b0);
    repeat (2) @(negedge clk);
    step("bne_zero0", V_BR_T);

    load(6'b000101, 6'd0, 1'b1);
    repeat (2) @(negedge clk);
    step("bne_zero1", V_BR_N);

    load(6'b000010, 6'd0, 1'b0);
    repeat (2) @(negedge clk);
    step("j_jump", V_JUMP);

    load(6'b000011, 6'd0, 1'b0);
    step("jal_fetch", V_FETCH);
    step("jal_decode", V_DECODE);
    step("jal_exec", V_JAL);

    load(6'b000000, 6'b001000, 1'b0);
    step("jr_fetch", V_FETCH);
    step("jr_decode", V_DECODE);
    step("jr_exec", V_JR);

    load(6'b111111, 6'd0, 1'b0);
    step("ill_fetch", V_FETCH);
    step("ill_decode", V_DECODE);
    step("ill_state", V_ILL);
    if (TRAP) begin
      for (int i = 0; i < 10; i++) step("ill_sticky", V_ILL);
      rst = 1'b0;
      #1;
      check("ill_reset", ctl, V_ZERO);
      @(negedge clk);
      rst = 1'b1;
      #1;
    end
    step("ill_next_fetch", V_FETCH);

    load(6'b100011, 6'd0, 1'b0);
    step("rmid_decode", V_DECODE);
    step("rmid_mem_addr", V_MADDR);
    check("rmid_mem_rd", ctl, V_MRD);
    rst = 1'b0;
    #1;
    check("rmid_reset_zero", ctl, V_ZERO);
    @(negedge clk);
    check("rmid_reset_hold", ctl, V_ZERO);
    rst = 1'b1;
    #1;
    step("rmid_fetch", V_FETCH);
    step("rmid_decode2", V_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS core; sits directly upstream of the datapath and drives every datapath control input.
- Consumes opcode, func and ZERO from the datapath and sequences fetch/decode/execute/memory/writeback, one state per clock.
- Also performs the ALU-operation decode, so no separate ALU-control block exists.

Parameters:
- ALU_OP_W, 3, width of alu_op.
- STATE_W, 4, width of the state register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- opcode  input  6  IR[31:26] from the datapath.
- func  input  6  IR[5:0] from the datapath.
- ZERO  input  1  ALU zero flag.
- pc_write, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write, alu_src_A, I_or_D, mem_write, mem_read  output  1 each  datapath controls.
- alu_src_B  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_src  output  2  00=ALU result, 01=jump target, 10=A (jr), 11=AluOut (branch target).
- alu_op  output  3  000=add, 001=sub, 010=and, 011=or, 100=slt.
- halted  output  1  trap indicator (see Optional Feature).

Behaviour:
- Mux selects are 0=first input, 1=second input:
  - I_or_D: 0=PC, 1=AluOut.
  - alu_src_A: 0=PC, 1=A.
  - reg_dst: 0=rt, 1=rd.
  - jal_reg: 1 forces r31.
  - mem_to_reg: 0=AluOut, 1=MDR.
  - pc_to_reg: 1 writes PC.
- Reset: while rst=0, state=FETCH and every output is forced to 0 (including halted). Reset mid-instruction abandons it. The first edge after release executes FETCH.
- Outputs are Moore-decoded from state, except pc_write in BRANCH, which also uses ZERO and opcode. Any signal not listed for a state is 0.
- FETCH: mem_read=1, I_or_D=0, IR_write=1, alu_src_A=0, alu_src_B=01, alu_op=add, pc_src=00, pc_write=1. Next state: DECODE.
- DECODE: alu_src_A=0, alu_src_B=11, alu_op=add (branch target into AluOut). Next state by opcode:
  - 000000 with func=001000: JR.
  - other 000000: R_EXEC.
  - 100011 (lw) or 101011 (sw): MEM_ADDR.
  - 001000 (addi) or 001010 (slti): I_EXEC.
  - 000100 (beq) or 000101 (bne): BRANCH.
  - 000010 (j): JUMP.
  - 000011 (jal): JAL.
  - anything else: ILLEGAL.
- MEM_ADDR: alu_src_A=1, alu_src_B=10, alu_op=add. Next: MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, I_or_D=1. Next: MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEM_WR: mem_write=1, I_or_D=1. Next: FETCH.
- R_EXEC: alu_src_A=1, alu_src_B=00. alu_op from func:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - any other func: add.
  - Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- I_EXEC: alu_src_A=1, alu_src_B=10, alu_op=add (addi) or slt (slti). Next: I_WB.
- I_WB: reg_write=1, reg_dst=0. Next: FETCH.
- BRANCH: alu_src_A=1, alu_src_B=00, alu_op=sub, pc_src=11. pc_write=ZERO for beq, ~ZERO for bne. Next: FETCH.
- JUMP: pc_src=01, pc_write=1. Next: FETCH.
- JAL: pc_src=01, pc_write=1, reg_write=1, jal_reg=1, pc_to_reg=1. This writes PC+4 to r31 on the same edge the PC updates. Next: FETCH.
- JR: pc_src=10, pc_write=1. Next: FETCH.
- Cycles per instruction:
  - lw: 5.
  - sw, R-type, addi, slti: 4.
  - beq, bne, j, jal, jr: 3.
- An unused state encoding returns to FETCH on the next edge with all outputs 0.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: ILLEGAL is a sticky HALT state. All controls are 0, halted=1, and the FSM stays there until rst=0.
- Undefined: ILLEGAL is a one-cycle NOP state. All controls are 0, next state is FETCH, and halted is tied to 0.

Test Plan:
- Reset and first fetch: hold rst=0 for 3 cycles → all outputs 0. After release: pc_write=1, IR_write=1, mem_read=1, alu_src_B=01.
- lw (opcode 100011) → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB over 5 cycles. MEM_WB shows reg_write=1, mem_to_reg=1, reg_dst=0.
- R-type (opcode 000000, func 101010) → R_EXEC alu_op=100, then R_WB reg_dst=1, reg_write=1. Next cycle is FETCH.
- beq (opcode 000100) with ZERO=1 → BRANCH pc_write=1, pc_src=11. Repeat with ZERO=0 → pc_write=0. bne (000101) with ZERO=0 → pc_write=1.
- jal (opcode 000011) → third cycle: pc_write=1, pc_src=01, reg_write=1, jal_reg=1, pc_to_reg=1. Also jr (opcode 000000, func 001000) → pc_src=10, pc_write=1.
- Opcode 111111 → with ILLEGAL_TRAP_EN: halted=1 and stays there for 10 cycles until rst pulse. Without it: one idle cycle, then FETCH. Also assert rst=0 during MEM_RD → outputs 0 immediately, FETCH after release.
